cc_banks_arb: RTL and testbench

- Two-requester arbiter and sequencer for the single-port 8192x64 cc_banks RW0 interface: a 13-bit address across four 2048x64 banks, selected by addr[12:11], with 1-cycle read latency.
- Shares the one RW0 port between requester A (core pipeline) and requester B (refill/DMA) with round-robin grant.
- Returns read data to the granted requester one cycle after grant.
- Optionally zero-fills the whole array after reset before accepting traffic.

---
 rtl/cc_banks_arb.sv | 179 +++++++++++++++++
 tb/tb_cc_banks_arb.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_banks_arb.sv
// cc_banks_arb
//   Two-requester round-robin arbiter/sequencer in front of the single-port
//   8192x64 cc_banks RW0 interface (four 2048x64 banks selected by
//   addr[12:11], 1-cycle read latency). Requester A is the core pipeline,
//   requester B is refill/DMA. Read data returns to the granted requester
//   the cycle after grant.
//
//   Optional feature: define CC_BANKS_ARB_INIT_EN to zero-fill the whole
//   array after reset before any request is accepted.
//
// Ports
//   RW0_clk, RW0_rst          clock, synchronous active-high reset
//   a_req_* / b_req_*         request channel (valid/ready, addr, wmode, wdata)
//   a_rsp_* / b_rsp_*         read response (valid, rdata), no back-pressure
//   mem_en/wmode/addr/wdata   drive RW0_en/wmode/addr/wdata
//   mem_rdata                 RW0_rdata, valid the cycle after a read
//   init_done                 array usable
module cc_banks_arb #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 64
) (
    input  logic              RW0_clk,
    input  logic              RW0_rst,

    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic              a_req_wmode,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_rsp_valid,
    output logic [DATA_W-1:0] a_rsp_rdata,

    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic              b_req_wmode,
    input  logic [DATA_W-1:0] b_req_wdata,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] b_rsp_rdata,

    output logic              mem_en,
    output logic              mem_wmode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              init_done
);

    typedef enum logic {
        GRANT_A,
        GRANT_B
    } grant_t;

    grant_t            last_grant;
    logic              run_en;
    logic              init_wr_en;
    logic [ADDR_W-1:0] init_addr;
    logic              gnt_a;
    logic              gnt_b;
    logic              rsp_a_q;
    logic              rsp_b_q;

`ifdef CC_BANKS_ARB_INIT_EN
    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] init_cnt;
    logic              init_wr;
    logic              in_run;

    always_ff @(posedge RW0_clk) begin
        if (RW0_rst) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge RW0_clk) begin
        if (RW0_rst) begin
            init_cnt <= '0;
        end else if (state == INIT) begin
            init_cnt <= init_cnt + ADDR_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        init_wr   = 1'b0;
        in_run    = 1'b0;
        case (state)
            INIT: begin
                init_wr = 1'b1;
                if (init_cnt == '1) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                in_run = 1'b1;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    // Outputs are gated by reset so the reset values hold while it is asserted.
    assign run_en     = in_run && !RW0_rst;
    assign init_wr_en = init_wr && !RW0_rst;
    assign init_addr  = init_cnt;
    assign init_done  = run_en;
`else
    assign run_en     = !RW0_rst;
    assign init_wr_en = 1'b0;
    assign init_addr  = '0;
    assign init_done  = 1'b1;
`endif

    // Round-robin: on contention the requester that did not win last time wins.
    assign gnt_a = run_en && a_req_valid && (!b_req_valid || last_grant == GRANT_B);
    assign gnt_b = run_en && b_req_valid && (!a_req_valid || last_grant == GRANT_A);

    assign a_req_ready = gnt_a;
    assign b_req_ready = gnt_b;

    always_ff @(posedge RW0_clk) begin
        if (RW0_rst) begin
            last_grant <= GRANT_B;
        end else if (gnt_a) begin
            last_grant <= GRANT_A;
        end else if (gnt_b) begin
            last_grant <= GRANT_B;
        end
    end

    // Only the response owner is registered; data comes straight from the RAM.
    always_ff @(posedge RW0_clk) begin
        if (RW0_rst) begin
            rsp_a_q <= 1'b0;
            rsp_b_q <= 1'b0;
        end else begin
            rsp_a_q <= gnt_a && !a_req_wmode;
            rsp_b_q <= gnt_b && !b_req_wmode;
        end
    end

    assign a_rsp_valid = rsp_a_q && !RW0_rst;
    assign b_rsp_valid = rsp_b_q && !RW0_rst;
    assign a_rsp_rdata = a_rsp_valid ? mem_rdata : '0;
    assign b_rsp_rdata = b_rsp_valid ? mem_rdata : '0;

    always_comb begin
        mem_en    = 1'b0;
        mem_wmode = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (init_wr_en) begin
            mem_en    = 1'b1;
            mem_wmode = 1'b1;
            mem_addr  = init_addr;
        end else if (gnt_a) begin
            mem_en    = 1'b1;
            mem_wmode = a_req_wmode;
            mem_addr  = a_req_addr;
            mem_wdata = a_req_wdata;
        end else if (gnt_b) begin
            mem_en    = 1'b1;
            mem_wmode = b_req_wmode;
            mem_addr  = b_req_addr;
            mem_wdata = b_req_wdata;
        end
    end

endmodule

// File: tb/tb_cc_banks_arb.sv
// tb_cc_banks_arb
//   Directed bench for cc_banks_arb with a behavioural 8192x64 RW0 memory.
//   Builds with or without CC_BANKS_ARB_INIT_EN.
module tb_cc_banks_arb;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              a_req_valid, a_req_ready, a_req_wmode, a_rsp_valid;
    logic [ADDR_W-1:0] a_req_addr;
    logic [DATA_W-1:0] a_req_wdata, a_rsp_rdata;
    logic              b_req_valid, b_req_ready, b_req_wmode, b_rsp_valid;
    logic [ADDR_W-1:0] b_req_addr;
    logic [DATA_W-1:0] b_req_wdata, b_rsp_rdata;
    logic              mem_en, mem_wmode, init_done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cc_banks_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .RW0_clk     (clk),
        .RW0_rst     (rst),
        .a_req_valid (a_req_valid),
        .a_req_ready (a_req_ready),
        .a_req_addr  (a_req_addr),
        .a_req_wmode (a_req_wmode),
        .a_req_wdata (a_req_wdata),
        .a_rsp_valid (a_rsp_valid),
        .a_rsp_rdata (a_rsp_rdata),
        .b_req_valid (b_req_valid),
        .b_req_ready (b_req_ready),
        .b_req_addr  (b_req_addr),
        .b_req_wmode (b_req_wmode),
        .b_req_wdata (b_req_wdata),
        .b_rsp_valid (b_rsp_valid),
        .b_rsp_rdata (b_rsp_rdata),
        .mem_en      (mem_en),
        .mem_wmode   (mem_wmode),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .init_done   (init_done)
    );

    // Power-up content: a nonzero pattern so the zero-fill is observable.
    function automatic logic [63:0] pattern(input int i);
        return {48'hF00D_0000_0000, 16'(i)};
    endfunction

    // Expected content of a location never written by a requester.
    function automatic logic [63:0] exp_rd(input int i);
`ifdef CC_BANKS_ARB_INIT_EN
        return 64'h0;
`else
        return pattern(i);
`endif
    endfunction

    logic [63:0] mem_model [0:8191];
    bit          model_ready = 1'b0;

    always @(posedge clk) begin
        if (!model_ready) begin
            for (int i = 0; i < 8192; i++) mem_model[i] <= pattern(i);
            model_ready <= 1'b1;
        end else if (mem_en) begin
            if (mem_wmode) mem_model[mem_addr] <= mem_wdata;
            else           mem_rdata <= mem_model[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic av, input logic aw, input logic [12:0] aa, input logic [63:0] ad,
                         input logic bv, input logic bw, input logic [12:0] ba, input logic [63:0] bd);
        a_req_valid = av; a_req_wmode = aw; a_req_addr = aa; a_req_wdata = ad;
        b_req_valid = bv; b_req_wmode = bw; b_req_addr = ba; b_req_wdata = bd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 13'h0, 64'h0, 1'b0, 1'b0, 13'h0, 64'h0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle();
        repeat (3) next_cycle();
        drive(1'b1, 1'b0, 13'h1A3F, 64'h0, 1'b1, 1'b0, 13'h0020, 64'h0);

        // Reset state
        @(negedge clk);
        check("rst_a_ready", a_req_ready, 0);
        check("rst_b_ready", b_req_ready, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_wmode", mem_wmode, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_a_rsp_valid", a_rsp_valid, 0);
        check("rst_b_rsp_valid", b_rsp_valid, 0);
        check("rst_a_rsp_rdata", a_rsp_rdata, 0);
`ifdef CC_BANKS_ARB_INIT_EN
        check("rst_init_done", init_done, 0);
`else
        check("rst_init_done", init_done, 1);
`endif
        next_cycle();
        rst = 1'b0;

`ifdef CC_BANKS_ARB_INIT_EN
        // Zero-fill sweep with both requesters pending
        for (int i = 0; i < 8192; i++) begin
            @(negedge clk);
            check("init_ctl", {a_req_ready, b_req_ready, mem_en, mem_wmode, init_done, mem_addr},
                  {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 13'(i)});
            check("init_wdata", mem_wdata, 64'h0);
            next_cycle();
        end
`endif

        // Contention: A,B,A,B from reset state
        @(negedge clk);
        check("c1_init_done", init_done, 1);
        check("c1_a_ready", a_req_ready, 1);
        check("c1_b_ready", b_req_ready, 0);
        check("c1_mem_en", mem_en, 1);
        check("c1_mem_wmode", mem_wmode, 0);
        check("c1_mem_addr", mem_addr, 13'h1A3F);
        next_cycle();
        drive(1'b1, 1'b0, 13'h0011, 64'h0, 1'b1, 1'b0, 13'h0020, 64'h0);
        @(negedge clk);
        check("c2_a_ready", a_req_ready, 0);
        check("c2_b_ready", b_req_ready, 1);
        check("c2_mem_addr", mem_addr, 13'h0020);
        check("c2_a_rsp_valid", a_rsp_valid, 1);
        check("c2_a_rsp_rdata", a_rsp_rdata, exp_rd(13'h1A3F));
        check("c2_b_rsp_valid", b_rsp_valid, 0);
        next_cycle();
        drive(1'b1, 1'b0, 13'h0011, 64'h0, 1'b1, 1'b0, 13'h0021, 64'h0);
        @(negedge clk);
        check("c3_a_ready", a_req_ready, 1);
        check("c3_b_ready", b_req_ready, 0);
        check("c3_mem_addr", mem_addr, 13'h0011);
        check("c3_b_rsp_valid", b_rsp_valid, 1);
        check("c3_b_rsp_rdata", b_rsp_rdata, exp_rd(13'h0020));
        check("c3_a_rsp_valid", a_rsp_valid, 0);
        next_cycle();
        drive(1'b1, 1'b0, 13'h0012, 64'h0, 1'b1, 1'b0, 13'h0021, 64'h0);
        @(negedge clk);
        check("c4_a_ready", a_req_ready, 0);
        check("c4_b_ready", b_req_ready, 1);
        check("c4_mem_addr", mem_addr, 13'h0021);
        check("c4_a_rsp_valid", a_rsp_valid, 1);
        check("c4_a_rsp_rdata", a_rsp_rdata, exp_rd(13'h0011));
        next_cycle();
        idle();
        @(negedge clk);
        check("c5_b_rsp_valid", b_rsp_valid, 1);
        check("c5_b_rsp_rdata", b_rsp_rdata, exp_rd(13'h0021));
        check("c5_a_rsp_valid", a_rsp_valid, 0);
        check("c5_mem_en", mem_en, 0);
        check("c5_a_ready", a_req_ready, 0);

        // Single write then read at the top address
        next_cycle();
        drive(1'b1, 1'b1, 13'h1FFF, 64'hDEADBEEF_CAFEF00D, 1'b0, 1'b0, 13'h0, 64'h0);
        @(negedge clk);
        check("wr_a_ready", a_req_ready, 1);
        check("wr_mem_wmode", mem_wmode, 1);
        check("wr_mem_addr", mem_addr, 13'h1FFF);
        check("wr_mem_wdata", mem_wdata, 64'hDEADBEEF_CAFEF00D);
        next_cycle();
        drive(1'b1, 1'b0, 13'h1FFF, 64'h0, 1'b0, 1'b0, 13'h0, 64'h0);
        @(negedge clk);
        check("rd_a_ready", a_req_ready, 1);
        check("rd_mem_wmode", mem_wmode, 0);
        check("rd_no_wr_rsp", a_rsp_valid, 0);
        next_cycle();
        idle();
        @(negedge clk);
        check("rd_a_rsp_valid", a_rsp_valid, 1);
        check("rd_a_rsp_rdata", a_rsp_rdata, 64'hDEADBEEF_CAFEF00D);
        check("rd_b_rsp_valid", b_rsp_valid, 0);

        // Bank crossing 0x07FF / 0x0800
        next_cycle();
        drive(1'b0, 1'b0, 13'h0, 64'h0, 1'b1, 1'b1, 13'h07FF, 64'h1);
        @(negedge clk);
        check("bk_w1_b_ready", b_req_ready, 1);
        next_cycle();
        drive(1'b0, 1'b0, 13'h0, 64'h0, 1'b1, 1'b1, 13'h0800, 64'h2);
        @(negedge clk);
        check("bk_w2_b_ready", b_req_ready, 1);
        next_cycle();
        drive(1'b0, 1'b0, 13'h0, 64'h0, 1'b1, 1'b0, 13'h07FF, 64'h0);
        @(negedge clk);
        check("bk_r1_bank", mem_addr[12:11], 0);
        next_cycle();
        drive(1'b0, 1'b0, 13'h0, 64'h0, 1'b1, 1'b0, 13'h0800, 64'h0);
        @(negedge clk);
        check("bk_r2_bank", mem_addr[12:11], 1);
        check("bk_rsp1_valid", b_rsp_valid, 1);
        check("bk_rsp1_rdata", b_rsp_rdata, 64'h1);
        next_cycle();
        idle();
        @(negedge clk);
        check("bk_rsp2_valid", b_rsp_valid, 1);
        check("bk_rsp2_rdata", b_rsp_rdata, 64'h2);

        // Read-after-write across requesters
        next_cycle();
        drive(1'b1, 1'b1, 13'h1234, 64'h55, 1'b0, 1'b0, 13'h0, 64'h0);
        @(negedge clk);
        check("raw_a_ready", a_req_ready, 1);
        next_cycle();
        drive(1'b0, 1'b0, 13'h0, 64'h0, 1'b1, 1'b0, 13'h1234, 64'h0);
        @(negedge clk);
        check("raw_b_ready", b_req_ready, 1);
        check("raw_no_wr_rsp", a_rsp_valid, 0);
        next_cycle();
        idle();
        @(negedge clk);
        check("raw_b_rsp_valid", b_rsp_valid, 1);
        check("raw_b_rsp_rdata", b_rsp_rdata, 64'h55);
        check("raw_a_rsp_valid", a_rsp_valid, 0);

        // Reset one cycle after a read grant
        next_cycle();
        drive(1'b1, 1'b0, 13'h1234, 64'h0, 1'b0, 1'b0, 13'h0, 64'h0);
        @(negedge clk);
        check("mr_a_ready", a_req_ready, 1);
        next_cycle();
        rst = 1'b1;
        idle();
        @(negedge clk);
        check("mr_a_rsp_valid", a_rsp_valid, 0);
        check("mr_a_rsp_rdata", a_rsp_rdata, 0);
        next_cycle();
        @(negedge clk);
        check("mr_a_rsp_valid2", a_rsp_valid, 0);
        next_cycle();
        rst = 1'b0;
        drive(1'b1, 1'b0, 13'h1FFF, 64'h0, 1'b1, 1'b0, 13'h07FF, 64'h0);
        @(negedge clk);
`ifdef CC_BANKS_ARB_INIT_EN
        check("mr_init_addr", mem_addr, 0);
        check("mr_init_en", mem_en, 1);
        check("mr_init_wmode", mem_wmode, 1);
        check("mr_a_ready_init", a_req_ready, 0);
        check("mr_init_done", init_done, 0);
`else
        check("mr_a_ready", a_req_ready, 1);
        check("mr_b_ready", b_req_ready, 0);
        check("mr_mem_addr", mem_addr, 13'h1FFF);
        next_cycle();
        idle();
        @(negedge clk);
        check("mr_a_rsp_rdata", a_rsp_rdata, 64'hDEADBEEF_CAFEF00D);
`endif
        next_cycle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
